// File: rtl/hilo_unit_pkg.sv
// Shared codes for the HI/LO multiply/divide unit: operand type, function field and FSM states.
// The MTHI/MTLO moves are built only when HILO_MOVE_EN is defined.
package hilo_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef logic [DATA_W-1:0] size_t;

    // MIPS OP_SPECIAL function codes
    typedef enum logic [5:0] {
        FUNC_MTHI  = 6'h11,
        FUNC_MTLO  = 6'h13,
        FUNC_MULT  = 6'h18,
        FUNC_MULTU = 6'h19,
        FUNC_DIV   = 6'h1A,
        FUNC_DIVU  = 6'h1B
    } func_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit_divu_core.sv
// Unsigned restoring divider: one shift-subtract step per enabled cycle.
// The down-counter is loaded with DATA_W-1 and cnt_zero flags the final step.
module divu_core
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem,
    output logic              cnt_zero
);

    logic [DATA_W-1:0] rem_p0;
    logic [DATA_W-1:0] quot_p0;
    logic [DATA_W-1:0] div_p0;
    logic [CNT_W-1:0]  cnt_p0;

    logic [DATA_W:0]   partial;
    logic [DATA_W:0]   diff;

    // partial < 2*divisor, so a clear top bit of diff means the subtract fits
    assign partial = {rem_p0, quot_p0[DATA_W-1]};
    assign diff    = partial - {1'b0, div_p0};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (load) begin
            cnt_p0 <= CNT_W'(DATA_W - 1);
        end else if (step && cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem_p0  <= '0;
            quot_p0 <= dividend;
            div_p0  <= divisor;
        end else if (step) begin
            if (!diff[DATA_W]) begin
                rem_p0  <= diff[DATA_W-1:0];
                quot_p0 <= {quot_p0[DATA_W-2:0], 1'b1};
            end else begin
                rem_p0  <= partial[DATA_W-1:0];
                quot_p0 <= {quot_p0[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign quot     = quot_p0;
    assign rem      = rem_p0;
    assign cnt_zero = (cnt_p0 == '0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: single-cycle MULT/MULTU, 33-cycle iterative DIV/DIVU with sign fix-up.
// Optional MTHI/MTLO moves are compiled in with the HILO_MOVE_EN macro.
module hilo_unit
    import hilo_unit_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  valid_i,
    input  func_t funct_i,
    input  size_t rs_i,
    input  size_t rt_i,
    output size_t hi_o,
    output size_t lo_o,
    output logic  stall_o
);

    hilo_state_t state_p0;
    size_t       hi_p0;
    size_t       lo_p0;
    logic        neg_q_p0;
    logic        neg_r_p0;

    logic        signed_div;
    logic        is_div;
    logic        rs_neg;
    logic        rt_neg;
    size_t       rs_mag;
    size_t       rt_mag;
    logic        div_load;
    logic        div_step;
    logic        cnt_zero;
    size_t       core_quot;
    size_t       core_rem;

    logic signed [2*DATA_W-1:0] rs_s;
    logic signed [2*DATA_W-1:0] rt_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;

    function automatic size_t negate(input size_t v);
        return size_t'(~v + 1'b1);
    endfunction

    function automatic size_t apply_sign(input size_t mag, input logic neg);
        return neg ? negate(mag) : mag;
    endfunction

    assign signed_div = (funct_i == FUNC_DIV);
    assign is_div     = (funct_i == FUNC_DIV) || (funct_i == FUNC_DIVU);
    assign rs_neg     = signed_div && rs_i[DATA_W-1];
    assign rt_neg     = signed_div && rt_i[DATA_W-1];
    assign rs_mag     = apply_sign(rs_i, rs_neg);
    assign rt_mag     = apply_sign(rt_i, rt_neg);

    assign div_load = valid_i && (state_p0 == IDLE) && is_div && (rt_i != '0);
    assign div_step = (state_p0 == DIVIDE);

    assign rs_s   = {{DATA_W{rs_i[DATA_W-1]}}, rs_i};
    assign rt_s   = {{DATA_W{rt_i[DATA_W-1]}}, rt_i};
    assign prod_s = rs_s * rt_s;
    assign prod_u = {{DATA_W{1'b0}}, rs_i} * {{DATA_W{1'b0}}, rt_i};

    divu_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_divu_core (
        .clk      (clk),
        .rst      (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (rs_mag),
        .divisor  (rt_mag),
        .quot     (core_quot),
        .rem      (core_rem),
        .cnt_zero (cnt_zero)
    );

    // Sign flags travel with the division; they need no reset
    always_ff @(posedge clk) begin
        if (div_load) begin
            neg_q_p0 <= rs_neg ^ rt_neg;
            neg_r_p0 <= rs_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= IDLE;
            hi_p0    <= '0;
            lo_p0    <= '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (valid_i) begin
                        case (funct_i)
                            FUNC_MULT: begin
                                hi_p0 <= prod_s[2*DATA_W-1:DATA_W];
                                lo_p0 <= prod_s[DATA_W-1:0];
                            end
                            FUNC_MULTU: begin
                                hi_p0 <= prod_u[2*DATA_W-1:DATA_W];
                                lo_p0 <= prod_u[DATA_W-1:0];
                            end
                            FUNC_DIV, FUNC_DIVU: begin
                                if (rt_i == '0) begin
                                    hi_p0 <= rs_i;
                                    lo_p0 <= '1;
                                end else begin
                                    state_p0 <= DIVIDE;
                                end
                            end
`ifdef HILO_MOVE_EN
                            FUNC_MTHI: hi_p0 <= rs_i;
                            FUNC_MTLO: lo_p0 <= rs_i;
`endif
                            default: ;
                        endcase
                    end
                end
                DIVIDE: begin
                    if (cnt_zero) begin
                        state_p0 <= FIXUP;
                    end
                end
                FIXUP: begin
                    lo_p0    <= apply_sign(core_quot, neg_q_p0);
                    hi_p0    <= apply_sign(core_rem, neg_r_p0);
                    state_p0 <= IDLE;
                end
                default: state_p0 <= IDLE;
            endcase
        end
    end

    assign hi_o    = hi_p0;
    assign lo_o    = lo_p0;
    assign stall_o = (state_p0 != IDLE);

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: multiplies, divides, divide-by-zero, stall hold, reset abort, moves.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic  clk;
    logic  reset;
    logic  valid_i;
    func_t funct_i;
    size_t rs_i;
    size_t rt_i;
    size_t hi_o;
    size_t lo_o;
    logic  stall_o;

    int tests;
    int fails;
    int stall_cnt;

    hilo_unit dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .funct_i (funct_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .stall_o (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input func_t f, input size_t a, input size_t b);
        valid_i = 1'b1;
        funct_i = f;
        rs_i    = a;
        rt_i    = b;
        tick();
        valid_i = 1'b0;
    endtask

    // counts cycles with stall_o=1, bounded so a stuck unit cannot hang the run
    task automatic wait_idle(output int n);
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        valid_i = 1'b1;
        funct_i = FUNC_MULTU;
        rs_i    = 32'h5;
        rt_i    = 32'h7;
        tick();
        tick();
        chk("reset_hi", hi_o, 32'h0);
        chk("reset_lo", lo_o, 32'h0);
        chk("reset_stall", {31'b0, stall_o}, 32'h0);
        reset   = 1'b0;
        valid_i = 1'b0;

        issue(FUNC_MULT, 32'hFFFF_FFFE, 32'h3);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFFA);
        chk("mult_stall", {31'b0, stall_o}, 32'h0);

        issue(FUNC_MULTU, 32'hFFFF_FFFF, 32'h2);
        chk("multu_hi", hi_o, 32'h1);
        chk("multu_lo", lo_o, 32'hFFFF_FFFE);

        issue(FUNC_DIVU, 32'd100, 32'd7);
        chk("divu_busy", {31'b0, stall_o}, 32'h1);
        chk("divu_hold_hi", hi_o, 32'h1);
        wait_idle(stall_cnt);
        chk("divu_stall_cycles", stall_cnt, 32'd33);
        chk("divu_lo", lo_o, 32'd14);
        chk("divu_hi", hi_o, 32'd2);

        issue(FUNC_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(stall_cnt);
        chk("div_neg_cycles", stall_cnt, 32'd33);
        chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);

        issue(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(stall_cnt);
        chk("div_ovf_lo", lo_o, 32'h8000_0000);
        chk("div_ovf_hi", hi_o, 32'h0);

        issue(FUNC_DIV, 32'd20, 32'hFFFF_FFFD);
        wait_idle(stall_cnt);
        chk("div_mixed_lo", lo_o, 32'hFFFF_FFFA);
        chk("div_mixed_hi", hi_o, 32'd2);

        issue(FUNC_DIVU, 32'h1234, 32'h0);
        chk("divz_stall", {31'b0, stall_o}, 32'h0);
        chk("divz_lo", lo_o, 32'hFFFF_FFFF);
        chk("divz_hi", hi_o, 32'h1234);

        issue(FUNC_DIV, 32'hFFFF_FFFB, 32'h0);
        chk("divz_s_hi", hi_o, 32'hFFFF_FFFB);

        issue(func_t'(6'h00), 32'hDEAD, 32'hBEEF);
        chk("unsup_hi", hi_o, 32'hFFFF_FFFB);
        chk("unsup_lo", lo_o, 32'hFFFF_FFFF);
        chk("unsup_stall", {31'b0, stall_o}, 32'h0);

        // MULTU held on valid_i during a division must wait for stall_o to fall
        issue(FUNC_DIVU, 32'd50, 32'd5);
        valid_i = 1'b1;
        funct_i = FUNC_MULTU;
        rs_i    = 32'd6;
        rt_i    = 32'd7;
        wait_idle(stall_cnt);
        chk("held_cycles", stall_cnt, 32'd33);
        chk("held_div_lo", lo_o, 32'd10);
        chk("held_div_hi", hi_o, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("held_mul_lo", lo_o, 32'd42);
        chk("held_mul_hi", hi_o, 32'd0);

        issue(FUNC_DIVU, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy", {31'b0, stall_o}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_stall", {31'b0, stall_o}, 32'h0);
        chk("abort_hi", hi_o, 32'h0);
        chk("abort_lo", lo_o, 32'h0);
        for (int i = 0; i < 40; i++) tick();
        chk("abort_no_write_lo", lo_o, 32'h0);
        chk("abort_no_write_hi", hi_o, 32'h0);

        issue(FUNC_MULTU, 32'd5, 32'd1);
        issue(FUNC_MTHI, 32'hAA, 32'h0);
`ifdef HILO_MOVE_EN
        chk("mthi_hi", hi_o, 32'hAA);
`else
        chk("mthi_hi", hi_o, 32'h0);
`endif
        chk("mthi_lo", lo_o, 32'd5);
        chk("mthi_stall", {31'b0, stall_o}, 32'h0);
        issue(FUNC_MTLO, 32'hBB, 32'h0);
`ifdef HILO_MOVE_EN
        chk("mtlo_lo", lo_o, 32'hBB);
        chk("mtlo_hi", hi_o, 32'hAA);
`else
        chk("mtlo_lo", lo_o, 32'd5);
        chk("mtlo_hi", hi_o, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 valid_i  input  1  an OP_SPECIAL HI/LO instruction is presented this cycle.
REQ-005 funct_i  input  func_t  function field: MULT, MULTU, DIV, DIVU, plus MTHI and MTLO when enabled.
REQ-006 rs_i  input  size_t  operand A (dividend/multiplicand/move source).
REQ-007 rt_i  input  size_t  operand B (divisor/multiplier).
REQ-008 hi_o  output  size_t  current HI register.
REQ-009 lo_o  output  size_t  current LO register.
REQ-010 stall_o  output  1  unit busy: upstream holds its instruction, and any MFHI/MFLO stalls.

Function
REQ-011 A request SHALL be accepted only on a rising edge with valid_i=1, stall_o=0 and a supported funct_i; other funct values SHALL be ignored with no state change.
REQ-012 MULT SHALL write the signed 64-bit product of rs_i and rt_i, with HI=[63:32] and LO=[31:0], at the accepting edge; stall_o SHALL stay 0.
REQ-013 MULTU SHALL do the same as MULT with an unsigned product.
REQ-014 The FSM SHALL have three states: IDLE, DIVIDE and FIXUP; stall_o SHALL be 1 exactly when the state is not IDLE, decoded from registered state only.
REQ-015 A DIV/DIVU with rt_i!=0 SHALL latch both operand magnitudes and the sign flags, then go IDLE->DIVIDE with a 5-bit counter set to 31.
REQ-016 In DIVIDE, each edge SHALL perform one restoring shift-subtract step; when counter=0 the FSM SHALL go to FIXUP, otherwise the counter decrements.
REQ-017 In FIXUP, the quotient SHALL be negated if the operand signs differ and the remainder SHALL take the dividend's sign (DIV only); LO=quotient and HI=remainder are written, and the FSM returns to IDLE.
REQ-018 Division latency: stall_o SHALL be 1 for exactly 33 cycles after acceptance; the result is visible on hi_o/lo_o in the first cycle stall_o=0.
REQ-019 DIV with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 with no other side effect.
REQ-020 Divide by zero (rt_i=0, DIV or DIVU) SHALL complete at the accepting edge with LO=0xFFFFFFFF, HI=rs_i and no stall.
REQ-021 While stall_o=1, valid_i SHALL be ignored; the pending instruction is accepted on the first edge where stall_o=0, including the edge that exits FIXUP is not an acceptance edge.
REQ-022 HI and LO SHALL hold their value unless written by an accepted request or FIXUP.

Reset
REQ-023 On reset, hi_o=0, lo_o=0, the state SHALL be IDLE, the counter 0 and stall_o=0; reset takes priority over valid_i.
REQ-024 Reset during DIVIDE or FIXUP SHALL abort the division, with no HI/LO write of partial results.

Configuration
REQ-025 With macro HILO_MOVE_EN defined, MTHI SHALL write HI=rs_i and MTLO SHALL write LO=rs_i at the accepting edge, with no stall and the other register unchanged.
REQ-026 Without HILO_MOVE_EN, MTHI and MTLO SHALL be treated as unsupported and ignored per REQ-011.

Structure
REQ-027 The shared codes package SHALL hold FUNC_MTHI and FUNC_MTLO in func_t, and a hilo_state_t enum for IDLE/DIVIDE/FIXUP.
REQ-028 The unsigned iterative step (remainder/quotient registers, counter) SHALL be a single sub-module, divu_core; sign handling stays in hilo_unit.

Verification
REQ-029 MULT, rs=0xFFFFFFFE (-2), rt=3 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall_o never 1.
REQ-030 DIVU, rs=100, rt=7 -> stall_o=1 for 33 cycles, then LO=14 and HI=2.
REQ-031 DIV, rs=-7 (0xFFFFFFF9), rt=2 -> after 33 stall cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF; then DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-032 DIVU with rt=0, rs=0x1234 -> no stall, LO=0xFFFFFFFF, HI=0x1234.
REQ-033 Start DIVU, assert reset at cycle 10 -> stall_o=0, HI=LO=0 next cycle; a MULTU held on valid_i during the stall is accepted only after stall_o falls.
REQ-034 With HILO_MOVE_EN: MTHI rs=0xAA -> HI=0xAA, LO unchanged; without HILO_MOVE_EN the same stimulus leaves HI unchanged.
